// File: rtl/uart_rx_fifo.sv
`timescale 1ns/1ps
// 8N1 oversampling UART receiver feeding a circular FIFO drained by a one-cycle read strobe.
// Good characters are pushed at the stop-bit sample; bad stop bits and full-FIFO drops pulse flags.
module uart_rx_fifo #(
  parameter int WIDTH        = 8,
  parameter int DIVISOR      = 434,
  parameter int SAMPLE_PHASE = 217,
  parameter int DEPTH        = 16,
  parameter int LEVEL        = 2
) (
  input  logic             clk,
  input  logic             i_reset,
  input  logic             i_rx_enable,
  input  logic             i_rx,
  input  logic             i_r_en,
  output logic [WIDTH-1:0] o_r_data,
  output logic             o_r_valid,
  output logic             o_full,
  output logic             o_afull,
  output logic             o_empty,
  output logic             o_aempty,
  output logic             o_frame_err,
  output logic             o_overflow,
  output logic             o_busy
);

  localparam int CW = $clog2(DIVISOR);
  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int AW = $clog2(DEPTH);
  localparam int NW = AW + 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic             rx_meta_q, rx_s_q;
  logic             at_sample, at_end, stop_eval;
  logic             push, pop, fe_d, ov_d, full_now, empty_now;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [NW-1:0]    count_q, count_d;

  always_ff @(posedge clk) begin
    if (i_reset) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= i_rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  assign at_sample = (cnt_q == CW'(SAMPLE_PHASE));
  assign at_end    = (cnt_q == CW'(DIVISOR - 1));
  assign full_now  = (count_q == NW'(DEPTH));
  assign empty_now = (count_q == '0);

  always_comb begin
    state_d   = state_q;
    cnt_d     = at_end ? '0 : cnt_q + CW'(1);
    idx_d     = idx_q;
    sr_d      = sr_q;
    stop_eval = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!rx_s_q) state_d = START;
      end
      START: begin
        if (at_sample && rx_s_q) begin
          state_d = IDLE;
        end else if (at_end) begin
          state_d = DATA;
          idx_d   = '0;
        end
      end
      DATA: begin
        if (at_sample) sr_d = {rx_s_q, sr_q[WIDTH-1:1]};
        if (at_end) begin
          if (idx_q == IW'(WIDTH - 1)) state_d = STOP;
          else                         idx_d   = idx_q + IW'(1);
        end
      end
      STOP: begin
        // Leave on the sample edge so a back-to-back start bit is caught early.
        if (at_sample) begin
          stop_eval = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (!i_rx_enable) begin
      state_d   = IDLE;
      stop_eval = 1'b0;
    end
  end

  assign push = stop_eval &&  rx_s_q && !full_now;
  assign ov_d = stop_eval &&  rx_s_q &&  full_now;
  assign fe_d = stop_eval && !rx_s_q;
  assign pop  = i_r_en && !empty_now;

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + NW'(1);
      2'b01:   count_d = count_q - NW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (i_reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      o_r_data    <= '0;
      o_r_valid   <= 1'b0;
      o_full      <= 1'b0;
      o_afull     <= 1'b0;
      o_empty     <= 1'b1;
      o_aempty    <= 1'b1;
      o_frame_err <= 1'b0;
      o_overflow  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      count_q     <= count_d;
      o_r_valid   <= pop;
      o_frame_err <= fe_d;
      o_overflow  <= ov_d;
      o_full      <= (count_d == NW'(DEPTH));
      o_afull     <= (count_d >= NW'(DEPTH - LEVEL));
      o_empty     <= (count_d == '0);
      o_aempty    <= (count_d <= NW'(LEVEL));
      if (push) wptr_q <= wptr_q + AW'(1);
      if (pop) begin
        rptr_q   <= rptr_q + AW'(1);
        o_r_data <= mem_q[rptr_q];
      end
    end
  end

  always_ff @(posedge clk) begin
    sr_q <= sr_d;
    if (push) mem_q[wptr_q] <= sr_d;
  end

  assign o_busy = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_fifo.sv
`timescale 1ns/1ps
// Scoreboard bench for uart_rx_fifo: serial frames in, expected characters queued, popped on o_r_valid.
module tb_uart_rx_fifo;
  localparam int W = 8, D = 16, SP = 8, DP = 4, LV = 1;
  localparam int PUSH_N = 3 + 9 * D + SP;

  logic         clk = 1'b0;
  logic         i_reset, i_rx_enable, i_rx, i_r_en;
  logic [W-1:0] o_r_data;
  logic         o_r_valid, o_full, o_afull, o_empty, o_aempty;
  logic         o_frame_err, o_overflow, o_busy;

  uart_rx_fifo #(.WIDTH(W), .DIVISOR(D), .SAMPLE_PHASE(SP), .DEPTH(DP), .LEVEL(LV)) dut (
    .clk(clk), .i_reset(i_reset), .i_rx_enable(i_rx_enable), .i_rx(i_rx), .i_r_en(i_r_en),
    .o_r_data(o_r_data), .o_r_valid(o_r_valid), .o_full(o_full), .o_afull(o_afull),
    .o_empty(o_empty), .o_aempty(o_aempty), .o_frame_err(o_frame_err),
    .o_overflow(o_overflow), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  int errors = 0, checks = 0, cyc = 0;
  int model_cnt = 0, e0 = 0;
  int fe_cnt = 0, ov_cnt = 0, rv_cnt = 0;
  int fe_cyc = 0, ov_cyc = 0, efall_cyc = 0, brise_cyc = 0, bfall_cyc = 0;
  logic prev_empty = 1'b1, prev_busy = 1'b0;
  logic [W-1:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (o_frame_err) begin fe_cnt++; fe_cyc = cyc; end
    if (o_overflow)  begin ov_cnt++; ov_cyc = cyc; end
    if (prev_empty && !o_empty) efall_cyc = cyc;
    if (!prev_busy && o_busy)   brise_cyc = cyc;
    if (prev_busy && !o_busy)   bfall_cyc = cyc;
    prev_empty = o_empty;
    prev_busy  = o_busy;
    if (o_r_valid) begin
      rv_cnt++;
      if (exp_q.size() == 0) chk("unexpected_valid", 32'(o_r_valid), 0);
      else                   chk("r_data", 32'(o_r_data), 32'(exp_q.pop_front()));
    end
  end

  task automatic send_frame(input logic [7:0] d, input logic stop, input bit track);
    logic [9:0] bits;
    bits = {stop, d, 1'b0};
    @(posedge clk); #1;
    e0 = cyc;
    if (track && stop) begin
      if (model_cnt < DP) begin exp_q.push_back(d); model_cnt++; end
    end
    for (int i = 0; i < 10; i++) begin
      i_rx = bits[i];
      repeat (D) @(posedge clk);
      #1;
    end
    i_rx = 1'b1;
    repeat (2 * D) @(posedge clk);
    #1;
  endtask

  task automatic read_one();
    @(posedge clk); #1;
    i_r_en = 1'b1;
    if (model_cnt > 0) model_cnt--;
    @(posedge clk); #1;
    i_r_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    int fe0, ov0, rv0, n;
    i_reset = 1'b1; i_rx_enable = 1'b1; i_rx = 1'b1; i_r_en = 1'b0;
    repeat (3) @(posedge clk);
    #1 i_reset = 1'b0;

    chk("rst_r_data",    32'(o_r_data), 0);
    chk("rst_r_valid",   32'(o_r_valid), 0);
    chk("rst_full",      32'(o_full), 0);
    chk("rst_afull",     32'(o_afull), 0);
    chk("rst_empty",     32'(o_empty), 1);
    chk("rst_aempty",    32'(o_aempty), 1);
    chk("rst_frame_err", 32'(o_frame_err), 0);
    chk("rst_overflow",  32'(o_overflow), 0);
    chk("rst_busy",      32'(o_busy), 0);

    send_frame(8'hA5, 1'b1, 1'b1);
    chk("a5_push_cycle", efall_cyc, e0 + PUSH_N + 1);
    chk("a5_busy_rise",  brise_cyc, e0 + 3);
    chk("a5_busy_fall",  bfall_cyc, e0 + PUSH_N + 1);
    chk("a5_not_empty",  32'(o_empty), 0);
    read_one();
    chk("a5_valid_cnt",  rv_cnt, 1);
    chk("a5_empty_after_read", 32'(o_empty), 1);

    fe0 = fe_cnt;
    send_frame(8'h3C, 1'b0, 1'b1);
    chk("fe_pulse_cnt",  fe_cnt, fe0 + 1);
    chk("fe_cycle",      fe_cyc, e0 + PUSH_N + 1);
    chk("fe_still_empty", 32'(o_empty), 1);
    send_frame(8'h01, 1'b1, 1'b1);
    read_one();
    chk("after_fe_valid_cnt", rv_cnt, 2);

    fe0 = fe_cnt; ov0 = ov_cnt;
    @(posedge clk); #1;
    e0 = cyc;
    i_rx = 1'b0;
    repeat (4) @(posedge clk);
    #1 i_rx = 1'b1;
    repeat (3 * D) @(posedge clk);
    #1;
    chk("glitch_busy_fall", bfall_cyc, e0 + SP + 4);
    chk("glitch_empty",     32'(o_empty), 1);
    chk("glitch_no_fe",     fe_cnt, fe0);
    chk("glitch_no_ov",     ov_cnt, ov0);

    ov0 = ov_cnt;
    for (int i = 0; i < 5; i++) begin
      send_frame(8'h10 + 8'(i), 1'b1, 1'b1);
      n = (i + 1 > DP) ? DP : i + 1;
      chk("lvl_empty",  32'(o_empty),  0);
      chk("lvl_aempty", 32'(o_aempty), 32'(n <= LV));
      chk("lvl_afull",  32'(o_afull),  32'(n >= DP - LV));
      chk("lvl_full",   32'(o_full),   32'(n == DP));
    end
    chk("ov_pulse_cnt", ov_cnt, ov0 + 1);
    chk("ov_cycle",     ov_cyc, e0 + PUSH_N + 1);
    rv0 = rv_cnt;
    for (int i = 0; i < 4; i++) read_one();
    chk("ov_drain_cnt", rv_cnt, rv0 + 4);
    chk("ov_drained_empty", 32'(o_empty), 1);

    rv0 = rv_cnt;
    fork
      send_frame(8'h77, 1'b1, 1'b1);
      begin
        @(posedge clk); #2;
        wait (cyc == e0 + PUSH_N);
        #1 i_r_en = 1'b1;
        @(posedge clk); #1 i_r_en = 1'b0;
      end
    join
    chk("coinc_no_valid", rv_cnt, rv0);
    chk("coinc_not_empty", 32'(o_empty), 0);
    chk("coinc_aempty", 32'(o_aempty), 1);
    read_one();
    chk("coinc_read_cnt", rv_cnt, rv0 + 1);

    fe0 = fe_cnt; ov0 = ov_cnt; rv0 = rv_cnt;
    fork
      send_frame(8'h55, 1'b1, 1'b0);
      begin
        @(posedge clk); #2;
        wait (cyc == e0 + 50);
        #1 i_rx_enable = 1'b0;
        @(posedge clk); #2;
        chk("en_abort_idle", 32'(o_busy), 0);
      end
    join
    i_rx_enable = 1'b1;
    chk("en_abort_empty", 32'(o_empty), 1);
    chk("en_abort_no_fe", fe_cnt, fe0);
    chk("en_abort_no_ov", ov_cnt, ov0);
    send_frame(8'hC3, 1'b1, 1'b1);
    read_one();
    chk("en_c3_read_cnt", rv_cnt, rv0 + 1);

    send_frame(8'h5A, 1'b1, 1'b1);
    chk("pre_rst_not_empty", 32'(o_empty), 0);
    fe0 = fe_cnt; ov0 = ov_cnt; rv0 = rv_cnt;
    fork
      send_frame(8'h66, 1'b1, 1'b0);
      begin
        @(posedge clk); #2;
        wait (cyc == e0 + 50);
        #1 i_reset = 1'b1;
        @(posedge clk); #2;
        chk("rst_abort_idle", 32'(o_busy), 0);
      end
    join
    i_reset = 1'b0;
    exp_q.delete();
    model_cnt = 0;
    chk("rst_abort_empty",  32'(o_empty), 1);
    chk("rst_abort_aempty", 32'(o_aempty), 1);
    chk("rst_abort_no_fe",  fe_cnt, fe0);
    chk("rst_abort_no_ov",  ov_cnt, ov0);
    send_frame(8'hC3, 1'b1, 1'b1);
    read_one();
    chk("rst_c3_read_cnt", rv_cnt, rv0 + 1);

    chk("sb_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
